// File: rtl/afe_reg_sc_pkg.sv
// Shared register map, descriptor type and handshake states for the
// successor AFE uDMA register interface.
package afe_reg_sc_pkg;

    // Per-channel page register offsets
    localparam logic [2:0] REG_SADDR    = 3'd0;
    localparam logic [2:0] REG_SIZE     = 3'd1;
    localparam logic [2:0] REG_CFG      = 3'd2;
    localparam logic [2:0] REG_EVT      = 3'd3;
    localparam logic [2:0] REG_CURRADDR = 3'd4;
    localparam logic [2:0] REG_BYTELEFT = 3'd5;

    // Generic page register offsets
    localparam logic [2:0] REG_IRQ_MASK    = 3'd0;
    localparam logic [2:0] REG_IRQ_STAT    = 3'd1;
    localparam logic [2:0] REG_AFE_CH_MASK = 3'd2;

    localparam logic [5:0] GEN_PAGE = 6'h3F;

    localparam int unsigned CFG_BIT_CONT = 0;
    localparam int unsigned CFG_BIT_EN   = 4;
    localparam int unsigned CFG_BIT_CLR  = 5;

    typedef struct packed {
        logic [31:0] startaddr;
        logic [31:0] size;
        logic        continuous;
    } l2_desc_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    function automatic logic [31:0] word_align(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/afe_reg_sc_chan.sv
// One L2 channel: shadow/active descriptor pair with deferred commit,
// enable/clear pulses and sticky done/error events.
module afe_reg_sc_chan
    import afe_reg_sc_pkg::*;
#(
    parameter int unsigned AW = 12,
    parameter int unsigned TW = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wdata,
    input  logic        wr_saddr,
    input  logic        wr_size,
    input  logic        wr_cfg,
    input  logic        wr_evt,
    input  logic        busy,
    input  logic        done,
    input  logic        err,
    output l2_desc_t    shadow,
    output l2_desc_t    active,
    output logic        pending,
    output logic        en,
    output logic        clr,
    output logic [1:0]  evt
);

    localparam logic [31:0] ADDR_MASK = word_align(32'((64'd1 << AW) - 64'd1));
    localparam logic [31:0] SIZE_MASK = word_align(32'((64'd1 << TW) - 64'd1));

    l2_desc_t shadow_d;
    logic     clr_req;
    logic     en_req;
    logic     commit_done;
    logic     commit;

    // clr beats en when both arrive in one CFG write
    assign clr_req     = wr_cfg & wdata[CFG_BIT_CLR];
    assign en_req      = wr_cfg & wdata[CFG_BIT_EN] & ~wdata[CFG_BIT_CLR];
    assign commit_done = pending & done & ~clr_req;
    assign commit      = (en_req & ~busy) | commit_done;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        shadow_d = shadow;
        if (wr_saddr) shadow_d.startaddr  = wdata & ADDR_MASK;
        if (wr_size)  shadow_d.size       = wdata & SIZE_MASK;
        if (wr_cfg)   shadow_d.continuous = wdata[CFG_BIT_CONT];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            en      <= 1'b0;
            clr     <= 1'b0;
            evt     <= 2'b00;
        end else begin
            // NOTE: sequential state uses <= so all registers sample pre-edge values.
            shadow <= shadow_d;
            if (commit) active <= shadow_d;
            en  <= commit;
            clr <= clr_req;
            if (clr_req)              pending <= 1'b0;
            else if (en_req && busy)  pending <= 1'b1;
            else if (commit_done)     pending <= 1'b0;
            // A new event outranks a W1C landing on the same edge
            evt <= (evt & ~(wr_evt ? wdata[1:0] : 2'b00)) | {err, done};
        end
    end

endmodule

// File: rtl/afe_reg_if_sc.sv
// Config-bus register interface for the AFE readout uDMA: per-channel L2
// descriptor pages, a generic IRQ/mask page and a registered read path.
module afe_reg_if_sc
    import afe_reg_sc_pkg::*;
#(
    parameter int unsigned L2_NUM_CHS     = 8,
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned L2_TRANS_SIZE  = 16,
    parameter int unsigned AFE_NUM_CHS    = 8,
    parameter int unsigned CFG_AWIDTH     = 11
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [31:0]                              cfg_wdata_i,
    input  logic [CFG_AWIDTH-1:0]                    cfg_addr_i,
    input  logic                                     cfg_valid_i,
    input  logic                                     cfg_rwn_i,
    output logic [31:0]                              cfg_rdata_o,
    output logic                                     cfg_ready_o,
    output logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0]     cfg_l2_startaddr_o,
    output logic [L2_NUM_CHS*L2_TRANS_SIZE-1:0]      cfg_l2_size_o,
    output logic [L2_NUM_CHS-1:0]                    cfg_l2_continuous_o,
    output logic [L2_NUM_CHS-1:0]                    cfg_l2_en_o,
    output logic [L2_NUM_CHS-1:0]                    cfg_l2_clr_o,
    input  logic [L2_NUM_CHS-1:0]                    cfg_l2_en_i,
    input  logic [L2_NUM_CHS-1:0]                    cfg_l2_done_i,
    input  logic [L2_NUM_CHS-1:0]                    cfg_l2_err_i,
    input  logic [L2_NUM_CHS*L2_AWIDTH_NOAL-1:0]     cfg_l2_curr_addr_i,
    input  logic [L2_NUM_CHS*L2_TRANS_SIZE-1:0]      cfg_l2_bytes_left_i,
    output logic [AFE_NUM_CHS-1:0]                   cfg_afe_ch_mask_o,
    output logic                                     irq_o
);

    localparam int unsigned AW     = L2_AWIDTH_NOAL;
    localparam int unsigned TW     = L2_TRANS_SIZE;
    localparam int unsigned MASK_W = (2 * L2_NUM_CHS > 32) ? 32 : 2 * L2_NUM_CHS;
    localparam int unsigned STAT_W = MASK_W / 2;

    logic [5:0]               page;
    logic [2:0]               regsel;
    state_e                   state_q, state_d;
    logic                     wr_en;
    logic                     rd_cap;
    logic [31:0]              rdata_d, rdata_q;
    l2_desc_t                 shadow [L2_NUM_CHS];
    l2_desc_t                 active [L2_NUM_CHS];
    logic [1:0]               evt    [L2_NUM_CHS];
    logic [L2_NUM_CHS-1:0]    pending;
    logic [MASK_W-1:0]        irq_mask_q;
    logic [AFE_NUM_CHS-1:0]   afe_mask_q;
    logic [31:0]              irq_stat;
    logic                     irq_q;
    logic                     gen_wr;

    assign page   = cfg_addr_i[8:3];
    assign regsel = cfg_addr_i[2:0];
    assign gen_wr = wr_en && (page == GEN_PAGE);

    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        wr_en       = 1'b0;
        rd_cap      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    if (cfg_rwn_i) begin
                        rd_cap  = 1'b1;
                        state_d = RESP;
                    end else begin
                        wr_en       = 1'b1;
                        cfg_ready_o = 1'b1;
                    end
                end
            end
            RESP: begin
                cfg_ready_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar c = 0; c < L2_NUM_CHS; c++) begin : g_ch
        logic sel;
        assign sel = wr_en && (page == 6'(c));

        afe_reg_sc_chan #(
            .AW (AW),
            .TW (TW)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .wdata    (cfg_wdata_i),
            .wr_saddr (sel && (regsel == REG_SADDR)),
            .wr_size  (sel && (regsel == REG_SIZE)),
            .wr_cfg   (sel && (regsel == REG_CFG)),
            .wr_evt   (sel && (regsel == REG_EVT)),
            .busy     (cfg_l2_en_i[c]),
            .done     (cfg_l2_done_i[c]),
            .err      (cfg_l2_err_i[c]),
            .shadow   (shadow[c]),
            .active   (active[c]),
            .pending  (pending[c]),
            .en       (cfg_l2_en_o[c]),
            .clr      (cfg_l2_clr_o[c]),
            .evt      (evt[c])
        );

        assign cfg_l2_startaddr_o[c*AW +: AW] = active[c].startaddr[AW-1:0];
        assign cfg_l2_size_o[c*TW +: TW]      = active[c].size[TW-1:0];
        assign cfg_l2_continuous_o[c]         = active[c].continuous;
    end

    // Only the first MASK_W/2 channels have mask bits and so can raise an IRQ
    always_comb begin
        irq_stat = '0;
        for (int c = 0; c < STAT_W; c++) begin
            irq_stat[c] = |(evt[c] & irq_mask_q[2*c +: 2]);
        end
    end

    always_comb begin
        rdata_d = '0;
        if (page == GEN_PAGE) begin
            case (regsel)
                REG_IRQ_MASK:    rdata_d = 32'(irq_mask_q);
                REG_IRQ_STAT:    rdata_d = irq_stat;
                REG_AFE_CH_MASK: rdata_d = 32'(afe_mask_q);
                default:         rdata_d = '0;
            endcase
        end else begin
            for (int c = 0; c < L2_NUM_CHS; c++) begin
                if (page == 6'(c)) begin
                    case (regsel)
                        REG_SADDR:    rdata_d = shadow[c].startaddr;
                        REG_SIZE:     rdata_d = shadow[c].size;
                        REG_CFG:      rdata_d = 32'({pending[c], 3'b000, cfg_l2_en_i[c],
                                                     3'b000, active[c].continuous});
                        REG_EVT:      rdata_d = 32'(evt[c]);
                        REG_CURRADDR: rdata_d = 32'(cfg_l2_curr_addr_i[c*AW +: AW]);
                        REG_BYTELEFT: rdata_d = 32'(cfg_l2_bytes_left_i[c*TW +: TW]);
                        default:      rdata_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            irq_mask_q <= '0;
            afe_mask_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rd_cap) rdata_q <= rdata_d;
            if (gen_wr && (regsel == REG_IRQ_MASK))    irq_mask_q <= cfg_wdata_i[MASK_W-1:0];
            if (gen_wr && (regsel == REG_AFE_CH_MASK)) afe_mask_q <= cfg_wdata_i[AFE_NUM_CHS-1:0];
            irq_q <= |irq_stat;
        end
    end

    assign cfg_rdata_o       = rdata_q;
    assign cfg_afe_ch_mask_o = afe_mask_q;
    assign irq_o             = irq_q;

endmodule

// File: tb/tb_afe_reg_if_sc.sv
// Self-checking bench for afe_reg_if_sc: directed scenarios plus random
// register traffic checked against a transaction-level register model.
module tb_afe_reg_if_sc;

    localparam int N      = 8;
    localparam int AW     = 12;
    localparam int TW     = 16;
    localparam int AFE    = 8;
    localparam int CAW    = 11;
    localparam int MASK_W = 16;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic [31:0]        cfg_wdata_i = '0;
    logic [CAW-1:0]     cfg_addr_i = '0;
    logic               cfg_valid_i = 1'b0;
    logic               cfg_rwn_i = 1'b0;
    logic [31:0]        cfg_rdata_o;
    logic               cfg_ready_o;
    logic [N*AW-1:0]    cfg_l2_startaddr_o;
    logic [N*TW-1:0]    cfg_l2_size_o;
    logic [N-1:0]       cfg_l2_continuous_o;
    logic [N-1:0]       cfg_l2_en_o;
    logic [N-1:0]       cfg_l2_clr_o;
    logic [N-1:0]       cfg_l2_en_i = '0;
    logic [N-1:0]       cfg_l2_done_i = '0;
    logic [N-1:0]       cfg_l2_err_i = '0;
    logic [N*AW-1:0]    cfg_l2_curr_addr_i = '0;
    logic [N*TW-1:0]    cfg_l2_bytes_left_i = '0;
    logic [AFE-1:0]     cfg_afe_ch_mask_o;
    logic               irq_o;

    always #5 clk_i = ~clk_i;

    afe_reg_if_sc #(
        .L2_NUM_CHS     (N),
        .L2_AWIDTH_NOAL (AW),
        .L2_TRANS_SIZE  (TW),
        .AFE_NUM_CHS    (AFE),
        .CFG_AWIDTH     (CAW)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .cfg_wdata_i         (cfg_wdata_i),
        .cfg_addr_i          (cfg_addr_i),
        .cfg_valid_i         (cfg_valid_i),
        .cfg_rwn_i           (cfg_rwn_i),
        .cfg_rdata_o         (cfg_rdata_o),
        .cfg_ready_o         (cfg_ready_o),
        .cfg_l2_startaddr_o  (cfg_l2_startaddr_o),
        .cfg_l2_size_o       (cfg_l2_size_o),
        .cfg_l2_continuous_o (cfg_l2_continuous_o),
        .cfg_l2_en_o         (cfg_l2_en_o),
        .cfg_l2_clr_o        (cfg_l2_clr_o),
        .cfg_l2_en_i         (cfg_l2_en_i),
        .cfg_l2_done_i       (cfg_l2_done_i),
        .cfg_l2_err_i        (cfg_l2_err_i),
        .cfg_l2_curr_addr_i  (cfg_l2_curr_addr_i),
        .cfg_l2_bytes_left_i (cfg_l2_bytes_left_i),
        .cfg_afe_ch_mask_o   (cfg_afe_ch_mask_o),
        .irq_o               (irq_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Register model: the programmer-visible state as plain arrays
    logic [31:0]  m_sh_saddr [N];
    logic [31:0]  m_sh_size  [N];
    logic [31:0]  m_act_saddr[N];
    logic [31:0]  m_act_size [N];
    logic         m_sh_cont  [N];
    logic         m_act_cont [N];
    logic         m_pend     [N];
    logic [1:0]   m_evt      [N];
    logic [31:0]  m_mask;
    logic [AFE-1:0] m_afe;
    logic [N-1:0] m_exp_en;
    logic [N-1:0] m_exp_clr;

    task automatic m_reset();
        for (int c = 0; c < N; c++) begin
            m_sh_saddr[c] = '0; m_sh_size[c] = '0; m_act_saddr[c] = '0; m_act_size[c] = '0;
            m_sh_cont[c] = 1'b0; m_act_cont[c] = 1'b0; m_pend[c] = 1'b0; m_evt[c] = 2'b00;
        end
        m_mask = '0;
        m_afe  = '1;
        m_exp_en = '0;
        m_exp_clr = '0;
    endtask

    task automatic m_commit(input int c);
        m_act_saddr[c] = m_sh_saddr[c];
        m_act_size[c]  = m_sh_size[c];
        m_act_cont[c]  = m_sh_cont[c];
        m_exp_en[c]    = 1'b1;
    endtask

    task automatic m_events(input logic [N-1:0] done, input logic [N-1:0] err);
        for (int c = 0; c < N; c++) begin
            m_evt[c] = m_evt[c] | {err[c], done[c]};
            if (done[c] && m_pend[c]) begin
                m_commit(c);
                m_pend[c] = 1'b0;
            end
        end
    endtask

    task automatic m_write(input int page, input int rg, input logic [31:0] d, input logic [N-1:0] done_c);
        m_exp_en = '0;
        m_exp_clr = '0;
        if (page < N) begin
            case (rg)
                0: m_sh_saddr[page] = d & 32'h0000_0FFC;
                1: m_sh_size[page]  = d & 32'h0000_FFFC;
                2: begin
                    m_sh_cont[page] = d[0];
                    if (d[5]) begin
                        m_pend[page] = 1'b0;
                        m_exp_clr[page] = 1'b1;
                    end else if (d[4]) begin
                        if (cfg_l2_en_i[page]) m_pend[page] = 1'b1;
                        else m_commit(page);
                    end
                end
                3: m_evt[page] = m_evt[page] & ~d[1:0];
                default: ;
            endcase
        end else if (page == 63) begin
            if (rg == 0) m_mask = 32'(d[MASK_W-1:0]);
            if (rg == 2) m_afe  = d[AFE-1:0];
        end
        m_events(done_c, '0);
    endtask

    function automatic logic [31:0] m_stat();
        logic [31:0] s;
        s = '0;
        for (int c = 0; c < N; c++)
            if (2 * c + 1 < MASK_W) s[c] = |(m_evt[c] & m_mask[2*c +: 2]);
        return s;
    endfunction

    function automatic logic [31:0] m_read(input int page, input int rg);
        logic [31:0] r;
        r = '0;
        if (page < N) begin
            case (rg)
                0: r = m_sh_saddr[page];
                1: r = m_sh_size[page];
                2: r = {23'b0, m_pend[page], 3'b0, cfg_l2_en_i[page], 3'b0, m_act_cont[page]};
                3: r = {30'b0, m_evt[page]};
                4: r = 32'(cfg_l2_curr_addr_i[page*AW +: AW]);
                5: r = 32'(cfg_l2_bytes_left_i[page*TW +: TW]);
                default: r = '0;
            endcase
        end else if (page == 63) begin
            case (rg)
                0: r = m_mask;
                1: r = m_stat();
                2: r = 32'(m_afe);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic check_outs(input string tag);
        logic [N*AW-1:0] sa;
        logic [N*TW-1:0] sz;
        logic [N-1:0]    ct;
        for (int c = 0; c < N; c++) begin
            sa[c*AW +: AW] = m_act_saddr[c][AW-1:0];
            sz[c*TW +: TW] = m_act_size[c][TW-1:0];
            ct[c]          = m_act_cont[c];
        end
        check({tag, ".startaddr"}, cfg_l2_startaddr_o, sa);
        check({tag, ".size"}, cfg_l2_size_o, sz);
        check({tag, ".cont"}, cfg_l2_continuous_o, ct);
        check({tag, ".afe_mask"}, cfg_afe_ch_mask_o, m_afe);
        check({tag, ".irq"}, irq_o, m_stat() != 0);
    endtask

    task automatic do_write(input int page, input int rg, input logic [31:0] d, input logic [N-1:0] done_c);
        @(negedge clk_i);
        cfg_valid_i   = 1'b1;
        cfg_rwn_i     = 1'b0;
        cfg_addr_i    = {2'b00, 6'(page), 3'(rg)};
        cfg_wdata_i   = d;
        cfg_l2_done_i = done_c;
        m_write(page, rg, d, done_c);
        #1 check("wr_ready", cfg_ready_o, 1'b1);
        @(negedge clk_i);
        check("wr_en_pulse", cfg_l2_en_o, m_exp_en);
        check("wr_clr_pulse", cfg_l2_clr_o, m_exp_clr);
        cfg_valid_i   = 1'b0;
        cfg_l2_done_i = '0;
        @(negedge clk_i);
        check("wr_en_end", cfg_l2_en_o, '0);
        check("wr_clr_end", cfg_l2_clr_o, '0);
        check_outs("wr");
    endtask

    task automatic do_read(input string tag, input int page, input int rg, output logic [31:0] data);
        logic [31:0] exp;
        int          cyc;
        @(negedge clk_i);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = {2'b00, 6'(page), 3'(rg)};
        exp = m_read(page, rg);
        #1 check({tag, ".ready_idle"}, cfg_ready_o, 1'b0);
        cyc = 0;
        while (cyc < 4) begin
            @(negedge clk_i);
            cyc++;
            if (cfg_ready_o) break;
        end
        check({tag, ".latency"}, cyc, 1);
        data = cfg_rdata_o;
        cfg_valid_i = 1'b0;
        check({tag, ".rdata"}, data, exp);
    endtask

    task automatic do_pulse(input logic [N-1:0] done, input logic [N-1:0] err);
        logic irq_prev;
        @(negedge clk_i);
        irq_prev = (m_stat() != 0);
        m_exp_en = '0;
        cfg_l2_done_i = done;
        cfg_l2_err_i  = err;
        m_events(done, err);
        @(negedge clk_i);
        check("ev_en_pulse", cfg_l2_en_o, m_exp_en);
        check("ev_irq_latency", irq_o, irq_prev);
        cfg_l2_done_i = '0;
        cfg_l2_err_i  = '0;
        @(negedge clk_i);
        check("ev_en_end", cfg_l2_en_o, '0);
        check_outs("ev");
    endtask

    function automatic int rand_page();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return $urandom_range(0, N - 1);
        if (r == 7) return 63;
        return $urandom_range(0, 63);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        m_reset();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset state
        check("rst_en", cfg_l2_en_o, '0);
        check("rst_clr", cfg_l2_clr_o, '0);
        check("rst_rdata", cfg_rdata_o, '0);
        check("rst_ready", cfg_ready_o, 1'b0);
        check("rst_afe_mask", cfg_afe_ch_mask_o, 8'hFF);
        check_outs("rst");
        do_read("rd_cfg0", 0, 2, rd);
        check("rd_cfg0_const", rd, 32'h0);
        do_read("rd_afe", 63, 2, rd);
        check("rd_afe_const", rd, 32'hFF);

        // Idle commit on channel 3
        do_write(3, 0, 32'h7FF, '0);
        do_write(3, 2, 32'h11, '0);
        check("ch3_saddr_o", cfg_l2_startaddr_o[3*AW +: AW], 12'h7FC);
        check("ch3_cont_o", cfg_l2_continuous_o[3], 1'b1);
        do_read("rd_saddr3", 3, 0, rd);
        check("rd_saddr3_const", rd, 32'h7FC);

        // Busy commit on channel 1, deferred until done
        cfg_l2_en_i[1] = 1'b1;
        do_write(1, 1, 32'h100, '0);
        do_write(1, 2, 32'h10, '0);
        do_read("rd_cfg1_pend", 1, 2, rd);
        check("cfg1_pend_const", rd, 32'h110);
        check("ch1_size_held", cfg_l2_size_o[1*TW +: TW], 16'h0);
        do_pulse(8'h02, '0);
        check("ch1_size_commit", cfg_l2_size_o[1*TW +: TW], 16'h100);
        do_read("rd_cfg1_done", 1, 2, rd);
        check("cfg1_done_const", rd, 32'h010);

        // Masked interrupt, set-wins W1C, clean W1C
        do_write(1, 3, 32'h3, '0);
        do_write(63, 0, 32'h4, '0);
        do_pulse(8'h02, '0);
        check("irq_set", irq_o, 1'b1);
        do_write(1, 3, 32'h1, 8'h02);
        do_read("rd_evt1", 1, 3, rd);
        check("evt1_setwins", rd, 32'h1);
        check("irq_hold", irq_o, 1'b1);
        do_write(1, 3, 32'h1, '0);
        check("irq_clear", irq_o, 1'b0);
        do_read("rd_stat", 63, 1, rd);

        // Unmapped page/register accesses
        do_read("rd_page20", 32, 0, rd);
        check("page20_const", rd, 32'h0);
        do_write(9, 0, 32'hFFFF_FFFF, '0);
        do_read("rd_gen7", 63, 7, rd);

        // clr drops pending; clr+en gives clr only
        cfg_l2_en_i[2] = 1'b1;
        do_write(2, 0, 32'h123, '0);
        do_write(2, 2, 32'h10, '0);
        do_write(2, 2, 32'h20, '0);
        do_read("rd_cfg2_clr", 2, 2, rd);
        check("cfg2_clr_const", rd, 32'h010);
        cfg_l2_en_i[2] = 1'b0;
        do_write(2, 2, 32'h30, '0);
        check("ch2_no_commit", cfg_l2_startaddr_o[2*AW +: AW], 12'h0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            int op, pg, rg;
            logic [N-1:0] dn;
            if ($urandom_range(0, 3) == 0) cfg_l2_en_i = N'($urandom);
            cfg_l2_curr_addr_i  = (N*AW)'({$urandom, $urandom, $urandom});
            cfg_l2_bytes_left_i = (N*TW)'({$urandom, $urandom, $urandom, $urandom});
            op = $urandom_range(0, 9);
            pg = rand_page();
            rg = $urandom_range(0, 7);
            if (op < 4) begin
                dn = (rg == 3 && pg < N) ? N'($urandom & $urandom) : '0;
                do_write(pg, rg, $urandom, dn);
            end else if (op < 7) begin
                do_read("rnd_rd", pg, rg, rd);
            end else begin
                do_pulse(N'($urandom & $urandom), N'($urandom & $urandom & $urandom));
            end
        end

        // Async reset in the middle of a read response
        @(negedge clk_i);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = {2'b00, 6'h3F, 3'd2};
        @(posedge clk_i);
        #1 check("mid_rd_resp", cfg_ready_o, 1'b1);
        rst_ni = 1'b0;
        #1 check("mid_rd_rst_ready", cfg_ready_o, 1'b0);
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        cfg_l2_en_i = '0;
        check("rst_hold_ready", cfg_ready_o, 1'b0);
        m_reset();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst2_ready", cfg_ready_o, 1'b0);
        check("rst2_rdata", cfg_rdata_o, '0);
        check_outs("rst2");
        do_read("rd_afe2", 63, 2, rd);
        check("rd_afe2_const", rd, 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
